decoder_2x4_hold: RTL and testbench

DECODER_2X4_HOLD -- requirements
Module: decoder_2x4_hold

---
 rtl/decoder_2x4_hold.sv | 60 ++++++
 tb/tb_decoder_2x4_hold.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_2x4_hold.sv
// 2-to-4 one-hot decoder that holds the selected line for HOLD_CYCLES cycles,
// then drops it with a one-cycle done pulse; en low during a hold aborts it.
module decoder_2x4_hold #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in_valid,
    input  logic [1:0] code,
    output logic       in_ready,
    output logic [3:0] y,
    output logic       busy,
    output logic       done
);

    localparam logic IDLE = 1'b0;
    localparam logic HOLD = 1'b1;

    // A zero hold length behaves like one cycle.
    localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES <= 1) ? 8'd0 : 8'(HOLD_CYCLES - 1);

    logic       state;
    logic [7:0] cnt;

    assign in_ready = (state == IDLE) && en;
    assign busy     = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            y     <= 4'b0000;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && in_ready) begin
                    state <= HOLD;
                    y     <= 4'b0001 << code;
                    cnt   <= HOLD_LOAD;
                end
            end else begin
                if (!en) begin
                    // Abort: drop the line silently, no completion pulse.
                    state <= IDLE;
                    y     <= 4'b0000;
                    cnt   <= 8'd0;
                end else if (cnt == 8'd0) begin
                    state <= IDLE;
                    y     <= 4'b0000;
                    done  <= 1'b1;
                end else begin
                    cnt <= cnt - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_decoder_2x4_hold.sv
// Randomized bench for decoder_2x4_hold: two instances (hold 4 and hold 1)
// compared every cycle against a remaining-cycles model, plus literal checks.
module tb_decoder_2x4_hold;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic [1:0] code;

    logic       in_ready4, busy4, done4;
    logic [3:0] y4;
    logic       in_ready1, busy1, done1;
    logic [3:0] y1;

    int vectors = 0;
    int errors  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    decoder_2x4_hold #(.HOLD_CYCLES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .code(code),
        .in_ready(in_ready4), .y(y4), .busy(busy4), .done(done4)
    );

    decoder_2x4_hold #(.HOLD_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .code(code),
        .in_ready(in_ready1), .y(y1), .busy(busy1), .done(done1)
    );

    // Model: a held line plus the number of cycles it still has to stay up.
    logic [3:0] my4 = 4'b0, my1 = 4'b0;
    int         rem4 = 0, rem1 = 0;
    logic       md4 = 1'b0, md1 = 1'b0;
    logic [3:0] ny4, ny1;
    int         nr4, nr1;
    logic       nd4, nd1;

    function automatic void model_next(input int h, input logic [3:0] yi, input int ri,
                                       input logic e, input logic v, input logic [1:0] c,
                                       output logic [3:0] yo, output int ro, output logic dn);
        yo = yi;
        ro = ri;
        dn = 1'b0;
        if (yi != 4'b0) begin
            if (!e) begin
                yo = 4'b0;
                ro = 0;
            end else begin
                ro = ri - 1;
                if (ro <= 0) begin
                    yo = 4'b0;
                    ro = 0;
                    dn = 1'b1;
                end
            end
        end else if (e && v) begin
            yo = 4'b0001 << c;
            ro = (h < 1) ? 1 : h;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            my4 <= 4'b0; rem4 <= 0; md4 <= 1'b0;
            my1 <= 4'b0; rem1 <= 0; md1 <= 1'b0;
        end else begin
            model_next(4, my4, rem4, en, in_valid, code, ny4, nr4, nd4);
            model_next(1, my1, rem1, en, in_valid, code, ny1, nr1, nd1);
            my4 <= ny4; rem4 <= nr4; md4 <= nd4;
            my1 <= ny1; rem1 <= nr1; md1 <= nd1;
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("y4",        y4,                 my4);
            check("busy4",     {3'b0, busy4},      {3'b0, my4 != 4'b0});
            check("done4",     {3'b0, done4},      {3'b0, md4});
            check("in_ready4", {3'b0, in_ready4},  {3'b0, (my4 == 4'b0) && en});
            check("y1",        y1,                 my1);
            check("busy1",     {3'b0, busy1},      {3'b0, my1 != 4'b0});
            check("done1",     {3'b0, done1},      {3'b0, md1});
            check("in_ready1", {3'b0, in_ready1},  {3'b0, (my1 == 4'b0) && en});
            check("onehot4",   {3'b0, $countones(y4) <= 1}, 4'b0001);
        end
    end

    task automatic drive(input logic r, input logic e, input logic v, input logic [1:0] c);
        @(posedge clk);
        #1;
        rst_n = r; en = e; in_valid = v; code = c;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; code = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_y4", y4, 4'b0000);
        check("rst_busy4", {3'b0, busy4}, 4'b0000);
        check("rst_done4", {3'b0, done4}, 4'b0000);
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        chk_on = 1'b1;

        // Basic: code 2 pulsed once.
        drive(1'b1, 1'b1, 1'b1, 2'd2);
        drive(1'b1, 1'b1, 1'b0, 2'd2);
        @(negedge clk);
        check("lit_y4_c1", y4, 4'b0100);
        check("lit_rdy4_c1", {3'b0, in_ready4}, 4'b0000);
        check("lit_y1_c1", y1, 4'b0100);
        drive(1'b1, 1'b1, 1'b0, 2'd1);
        @(negedge clk);
        check("lit_y4_c2", y4, 4'b0100);
        check("lit_y1_c2", y1, 4'b0000);
        check("lit_done1_c2", {3'b0, done1}, 4'b0001);
        drive(1'b1, 1'b1, 1'b0, 2'd3);
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        check("lit_y4_c4", y4, 4'b0100);
        check("lit_done4_c4", {3'b0, done4}, 4'b0000);
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        check("lit_y4_c5", y4, 4'b0000);
        check("lit_done4_c5", {3'b0, done4}, 4'b0001);
        check("lit_rdy4_c5", {3'b0, in_ready4}, 4'b0001);
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        check("lit_done4_c6", {3'b0, done4}, 4'b0000);

        // Abort: code 3 accepted, en dropped two cycles later.
        drive(1'b1, 1'b1, 1'b1, 2'd3);
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 1'b1, 2'd1);
        drive(1'b1, 1'b0, 1'b1, 2'd1);
        @(negedge clk);
        check("lit_abort_y4", y4, 4'b0000);
        check("lit_abort_done4", {3'b0, done4}, 4'b0000);
        check("lit_abort_rdy4", {3'b0, in_ready4}, 4'b0000);

        // All codes back-to-back with in_valid held high.
        for (int i = 0; i < 24; i++) drive(1'b1, 1'b1, 1'b1, 2'(i / 6));

        // Reset in the middle of a hold, then a normal accept of code 0.
        drive(1'b1, 1'b1, 1'b1, 2'd1);
        drive(1'b1, 1'b1, 1'b0, 2'd1);
        drive(1'b0, 1'b1, 1'b0, 2'd1);
        #1;
        check("lit_rst_mid_y4", y4, 4'b0000);
        drive(1'b1, 1'b1, 1'b1, 2'd0);
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        check("lit_after_rst_y4", y4, 4'b0001);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 149) != 0),
                  ($urandom_range(0, 19) != 0),
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)));
        end
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
